// File: rtl/spi_adc_pkg.sv
// Shared constants, FSM encodings and response-frame helper
// for the AD7908-style SPI responder.
package spi_adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CTRL_BITS  = 12;
  localparam int DATA_BITS  = 8;
  localparam int ADDR_BITS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int CW_WRITE    = 11;
  localparam int CW_SEQ      = 10;
  localparam int CW_ADDR_MSB = 8;
  localparam int CW_ADDR_LSB = 6;
  localparam int CW_PM1      = 5;
  localparam int CW_PM0      = 4;
  localparam int CW_RANGE    = 1;
  localparam int CW_CODING   = 0;

  localparam int RSP_ADDR_MSB = 13;
  localparam int RSP_ADDR_LSB = 11;
  localparam int RSP_DATA_MSB = 10;
  localparam int RSP_DATA_LSB = 3;

  function automatic logic [FRAME_BITS-1:0] build_rsp(
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] data
  );
    logic [FRAME_BITS-1:0] r;
    r = '0;
    r[RSP_ADDR_MSB:RSP_ADDR_LSB] = addr;
    r[RSP_DATA_MSB:RSP_DATA_LSB] = data;
    return r;
  endfunction

endpackage

// File: rtl/spi_adc_responder_sync.sv
// Pin synchronizer with a trailing edge register; rise/fall
// pulses appear three clocks after the pin changes.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q    <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~q;
      fall <= ~sync[STAGES-1] & q;
    end
  end

endmodule

// File: rtl/spi_adc_responder.sv
// AD7908 emulation: returns the previously addressed channel
// and captures the incoming 12-bit control word.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_sck,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_data,
  output logic [CTRL_BITS-1:0]        ctrl_word,
  output logic                        ctrl_valid,
  output logic                        frame_error,
  output logic [ADDR_BITS-1:0]        cur_addr
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst(rst), .d(spi_sck),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = sck_q ^ cs_q ^ mosi_rise ^ mosi_fall;

  state_t                 state, state_nxt;
  logic [4:0]             bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0]  shreg_in, shreg_in_nxt;
  logic [FRAME_BITS-1:0]  shreg_out, shreg_out_nxt;
  logic [CTRL_BITS-1:0]   cw_in;
  logic [CTRL_BITS-1:0]   ctrl_word_nxt;
  logic [ADDR_BITS-1:0]   cur_addr_nxt;
  logic                   oe_nxt, valid_nxt, error_nxt;
  logic [DATA_BITS-1:0]   ch_sel;

  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_addr == k[ADDR_BITS-1:0]) begin
        ch_sel = ch_data[k*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign cw_in = shreg_in[FRAME_BITS-1 -: CTRL_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // CS edges are tested first so they win over a coincident SCLK edge
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_in_nxt  = shreg_in;
    shreg_out_nxt = shreg_out;
    ctrl_word_nxt = ctrl_word;
    cur_addr_nxt  = cur_addr;
    oe_nxt        = spi_miso_oe;
    valid_nxt     = 1'b0;
    error_nxt     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          shreg_out_nxt = build_rsp(cur_addr, ch_sel);
          shreg_in_nxt  = '0;
          bit_cnt_nxt   = '0;
          oe_nxt        = 1'b1;
          state_nxt     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          error_nxt = 1'b1;
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end else if (sck_rise) begin
          shreg_in_nxt = {shreg_in[FRAME_BITS-2:0], mosi_q};
          bit_cnt_nxt  = bit_cnt + 5'd1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ST_HOLD;
          end
        end else if (sck_fall && bit_cnt != 5'd0) begin
          shreg_out_nxt = {shreg_out[FRAME_BITS-2:0], 1'b0};
        end
      end
      ST_HOLD: begin
        if (cs_rise) begin
          ctrl_word_nxt = cw_in;
          valid_nxt     = 1'b1;
          oe_nxt        = 1'b0;
          state_nxt     = ST_IDLE;
          if (cw_in[CW_WRITE]) begin
            cur_addr_nxt = cw_in[CW_ADDR_MSB:CW_ADDR_LSB];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        oe_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg_in    <= '0;
      shreg_out   <= '0;
      ctrl_word   <= '0;
      cur_addr    <= '0;
      spi_miso_oe <= 1'b0;
      ctrl_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_nxt;
      shreg_in    <= shreg_in_nxt;
      shreg_out   <= shreg_out_nxt;
      ctrl_word   <= ctrl_word_nxt;
      cur_addr    <= cur_addr_nxt;
      spi_miso_oe <= oe_nxt;
      ctrl_valid  <= valid_nxt;
      frame_error <= error_nxt;
    end
  end

  assign spi_miso = (state == ST_SHIFT) ? shreg_out[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: frames, short frame,
// read-only control word and reset in mid-frame.
module tb_spi_adc_responder;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [63:0] ch_data;
  logic [11:0] ctrl_word;
  logic        ctrl_valid;
  logic        frame_error;
  logic [2:0]  cur_addr;

  int n_chk;
  int n_err;
  int vcnt;
  int ecnt;
  int act;

  spi_adc_responder dut (
    .clk(clk),
    .rst(rst),
    .spi_sck(spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .ch_data(ch_data),
    .ctrl_word(ctrl_word),
    .ctrl_valid(ctrl_valid),
    .frame_error(frame_error),
    .cur_addr(cur_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    vcnt = 0;
    ecnt = 0;
    act  = 0;
  end

  always @(negedge clk) begin
    if (ctrl_valid) vcnt++;
    if (frame_error) ecnt++;
    if (spi_miso || spi_miso_oe) act++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic one_bit(input logic m, output logic s);
    spi_mosi = m;
    wait_clk(5);
    s = spi_miso;
    spi_sck = 1'b1;
    wait_clk(5);
    spi_sck = 1'b0;
  endtask

  task automatic frame(input  logic [15:0] mosi_w,
                       input  int          nbits,
                       input  int          mid_bit,
                       input  logic [63:0] ch_mid,
                       output logic [15:0] miso_w,
                       output logic        oe_seen);
    logic b;
    miso_w = '0;
    spi_cs_n = 1'b0;
    wait_clk(5);
    oe_seen = spi_miso_oe;
    for (int i = 0; i < nbits; i++) begin
      if (i == mid_bit) ch_data = ch_mid;
      one_bit(mosi_w[15-i], b);
      miso_w[15-i] = b;
    end
    spi_mosi = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_up();
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  logic [15:0] rx;
  logic        oe;
  int          v0, e0, a0;
  logic        b;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    ch_data  = 64'h7766_5544_3322_3CA5;
    wait_clk(5);
    rst = 1'b0;
    v0 = vcnt;
    e0 = ecnt;
    a0 = act;
    wait_clk(100);
    chk("rst_miso", 32'(spi_miso), 32'h0);
    chk("rst_oe", 32'(spi_miso_oe), 32'h0);
    chk("rst_ctrl", 32'(ctrl_word), 32'h0);
    chk("rst_addr", 32'(cur_addr), 32'h0);
    chk("rst_pulses", 32'(vcnt - v0 + ecnt - e0), 32'h0);
    chk("rst_act", 32'(act - a0), 32'h0);

    // write frame selecting channel 1
    v0 = vcnt;
    frame(16'h8730, 16, -1, '0, rx, oe);
    chk("f1_oe", 32'(oe), 32'h1);
    chk("f1_miso", 32'(rx), 32'h0528);
    chk("f1_noearly", 32'(vcnt - v0), 32'h0);
    cs_up();
    chk("f1_valid", 32'(vcnt - v0), 32'h1);
    chk("f1_ctrl", 32'(ctrl_word), 32'h873);
    chk("f1_addr", 32'(cur_addr), 32'h1);
    chk("f1_oe_off", 32'(spi_miso_oe), 32'h0);

    // ch1 changes mid-frame; snapshot must hold
    v0 = vcnt;
    frame(16'h0000, 16, 6, 64'h7766_5544_3322_FFA5, rx, oe);
    chk("f2_miso", 32'(rx), 32'h09E0);
    cs_up();
    chk("f2_valid", 32'(vcnt - v0), 32'h1);
    chk("f2_addr", 32'(cur_addr), 32'h1);

    // short frame aborts without commit
    v0 = vcnt;
    e0 = ecnt;
    frame(16'hFFFF, 7, -1, '0, rx, oe);
    cs_up();
    chk("f3_err", 32'(ecnt - e0), 32'h1);
    chk("f3_valid", 32'(vcnt - v0), 32'h0);
    chk("f3_addr", 32'(cur_addr), 32'h1);
    chk("f3_ctrl", 32'(ctrl_word), 32'h000);

    // read-only control word, ADD=101
    v0 = vcnt;
    frame(16'h1730, 16, -1, '0, rx, oe);
    chk("f4_miso", 32'(rx), 32'h0FF8);
    cs_up();
    chk("f4_valid", 32'(vcnt - v0), 32'h1);
    chk("f4_ctrl", 32'(ctrl_word), 32'h173);
    chk("f4_addr", 32'(cur_addr), 32'h1);

    // write ADD=101 so reset has something to clear
    frame(16'hD730, 16, -1, '0, rx, oe);
    cs_up();
    chk("f5_addr", 32'(cur_addr), 32'h5);

    // reset in mid-frame, CS held low afterwards
    spi_cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 5; i++) one_bit(1'b1, b);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    v0 = vcnt;
    e0 = ecnt;
    a0 = act;
    for (int i = 0; i < 11; i++) one_bit(1'b1, b);
    wait_clk(6);
    spi_cs_n = 1'b1;
    wait_clk(10);
    chk("rm_act", 32'(act - a0), 32'h0);
    chk("rm_pulses", 32'(vcnt - v0 + ecnt - e0), 32'h0);
    chk("rm_addr", 32'(cur_addr), 32'h0);
    chk("rm_ctrl", 32'(ctrl_word), 32'h000);

    // clean frame after reset returns ch0
    v0 = vcnt;
    frame(16'h0000, 16, -1, '0, rx, oe);
    chk("f6_miso", 32'(rx), 32'h0528);
    cs_up();
    chk("f6_valid", 32'(vcnt - v0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
